// File: rtl/bram_stream_reader.sv
// Burst reader: issues sequential BRAM reads and streams the returned words
// through a 2-entry skid FIFO with valid/ready handshaking.
`default_nettype none

module bram_stream_reader #(
  parameter int DW = 18,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   rem;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] addr_hold;
  logic          inflight;
  logic          inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          done_q;

  logic          pop;
  logic          push;
  logic          last_hs;
  logic          issue;
  logic          issue_last;
  logic          zero_start;
  logic [AW-1:0] issue_addr;
  logic [2:0]    pending;
  logic [2:0]    limit;

  assign m_valid = (count != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = m_valid & fifo_last[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign last_hs = pop & m_last;
  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign rd_addr = issue ? issue_addr : addr_hold;

  // Credit check: words buffered plus words returning must fit after this pop.
  assign pending = {1'b0, count} + {2'b00, inflight};
  assign limit   = 3'd2 + {2'b00, pop};

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr;
    zero_start = 1'b0;
    unique case (state)
      IDLE: begin
        issue_addr = base_addr;
        if (start) begin
          if (length == '0) begin
            zero_start = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_last = (length == (AW+1)'(1));
            state_nxt  = RUN;
          end
        end
      end
      RUN: begin
        if ((rem != '0) && (pending < limit)) begin
          issue      = 1'b1;
          issue_last = (rem == (AW+1)'(1));
        end
        if ((rem == '0) || issue_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done_q        <= 1'b0;
      rem           <= '0;
      next_addr     <= '0;
      addr_hold     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
    end else begin
      state         <= state_nxt;
      done_q        <= zero_start | ((state == DRAIN) & last_hs);
      inflight      <= issue;
      inflight_last <= issue_last;
      if (issue) begin
        addr_hold <= issue_addr;
        next_addr <= issue_addr + AW'(1);
        rem       <= ((state == IDLE) ? length : rem) - (AW+1)'(1);
      end
      if (push) begin
        fifo_data[wr_ptr] <= rd_dout;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 1-cycle BRAM.
`default_nettype none

module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] length = '0;
  logic        busy;
  logic        done;
  logic [13:0] rd_addr;
  logic [17:0] rd_dout = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [17:0] m_data;
  logic        m_last;

  int n_checks = 0;
  int n_fail   = 0;

  bram_stream_reader #(.DW(18), .AW(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_dout   (rd_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] memval(input logic [13:0] a);
    return {a[3:0], a} ^ 18'h15A5A;
  endfunction

  always @(posedge clk) rd_dout <= memval(rd_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
    chk({tag, "_valid"},   m_valid, 0);
    chk({tag, "_last"},    m_last,  0);
    chk({tag, "_data"},    m_data,  0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // Launches a burst in the current cycle (cycle 0) and returns in the done cycle.
  task automatic burst(input logic [13:0] b, input logic [14:0] len,
                       input bit toggle, input int junk_cyc);
    int          idx;
    int          c;
    bit          held;
    bit          fin;
    logic [17:0] hd;
    logic        hl;
    logic [13:0] a;
    idx = 0; c = 0; held = 0; fin = 0; hd = '0; hl = 0;
    start = 1'b1; base_addr = b; length = len; m_ready = 1'b1;
    #1;
    chk("rd_addr_first", rd_addr, b);
    while (!fin && c < 200) begin
      tick();
      c++;
      start = (c == junk_cyc);
      base_addr = start ? 14'h0080 : b;
      length    = start ? 15'd5 : len;
      #1;
      if (held) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data",  m_data,  hd);
        chk("stall_last",  m_last,  hl);
      end
      if (idx == int'(len)) begin
        chk("done_pulse", done, 1);
        chk("busy_end",   busy, 0);
        chk("valid_end",  m_valid, 0);
        if (!toggle) chk("done_cycle", c, int'(len) + 2);
        fin = 1;
      end else begin
        chk("done_low", done, 0);
        chk("busy_high", busy, 1);
        if (!toggle) chk("valid_timing", m_valid, (c >= 2));
        m_ready = toggle ? (c % 2 == 0) : 1'b1;
        if (m_valid) begin
          held = !m_ready;
          hd = m_data;
          hl = m_last;
          if (m_ready) begin
            a = b + idx[13:0];
            chk("beat_data", m_data, memval(a));
            chk("beat_last", m_last, (idx == int'(len) - 1));
            idx++;
          end
        end else begin
          held = 0;
        end
      end
    end
    chk("burst_finished", fin, 1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal burst, then an address wrap across the top of memory.
    burst(14'h0010, 15'd4, 0, -1);
    tick();
    chk("done_falls", done, 0);
    burst(14'h3FFE, 15'd4, 0, -1);
    tick();

    // Sink stalls every other cycle.
    burst(14'h0100, 15'd8, 1, -1);
    tick();
    m_ready = 1'b1;

    // Zero-length start.
    start = 1'b1; base_addr = 14'h0005; length = 15'd0;
    tick();
    start = 1'b0;
    chk("zero_done",  done,    1);
    chk("zero_busy",  busy,    0);
    chk("zero_valid", m_valid, 0);
    tick();
    chk("zero_done_falls", done, 0);
    chk("zero_valid2", m_valid, 0);

    // Reset in the middle of a length-10 burst after three beats.
    start = 1'b1; base_addr = 14'h0200; length = 15'd10; m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_beat0", m_data, memval(14'h0200));
    tick();
    tick();
    chk("mid_beat2", m_data, memval(14'h0202));
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_done",  done,    0);
      chk("post_reset_valid", m_valid, 0);
      chk("post_reset_busy",  busy,    0);
    end
    burst(14'h0000, 15'd2, 0, -1);
    tick();

    // Start while busy is ignored; start in the done cycle chains a new burst.
    burst(14'h0040, 15'd3, 0, 2);
    burst(14'h0060, 15'd2, 0, -1);
    tick();
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
